// File: rtl/mr1_bus_pkg.sv
// Shared types and access-decoding helpers for the MR1 data-bus responder.
package mr1_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StReset,
    StIdle,
    StRdWait,
    StResp
  } state_e;

  localparam int unsigned LFSR_W      = 8;
  localparam int unsigned STALL_CNT_W = 3;

  // Byte lanes touched by an access of the given size at the given in-word offset.
  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
    unique case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Size 3 is never legal, so it is reported alongside alignment faults.
  function automatic logic misaligned(input size_e size, input logic [1:0] lane);
    unique case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mr1_dbus_responder_if.sv
// MR1 data-bus command/response bundle; master is the core, slave is the memory responder.
interface mr1_dbus_responder_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_payload_wr;
  logic [31:0] cmd_payload_address;
  logic [31:0] cmd_payload_data;
  logic [1:0]  cmd_payload_size;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;

  modport master (
    output cmd_valid,
    output cmd_payload_wr,
    output cmd_payload_address,
    output cmd_payload_data,
    output cmd_payload_size,
    input  cmd_ready,
    input  rsp_ready,
    input  rsp_data,
    input  rsp_error
  );

  modport slave (
    input  cmd_valid,
    input  cmd_payload_wr,
    input  cmd_payload_address,
    input  cmd_payload_data,
    input  cmd_payload_size,
    output cmd_ready,
    output rsp_ready,
    output rsp_data,
    output rsp_error
  );

endinterface

// File: rtl/mr1_stall_gen.sv
// Bounded pseudo-random command back-pressure: an 8-bit LFSR proposes stalls, a run counter
// caps how many consecutive stalls a waiting command can see.
module mr1_stall_gen
  import mr1_bus_pkg::*;
#(
  parameter int unsigned       MAX_STALL = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic clock,
  input  logic reset,
  input  logic idle,
  input  logic cmdValid,
  output logic stall
);

  localparam logic [STALL_CNT_W-1:0] CntOne = STALL_CNT_W'(1);

  logic [LFSR_W-1:0]      lfsrQ, lfsrD;
  logic [STALL_CNT_W-1:0] stallCntQ, stallCntD;
  logic                   feedback;

  always_comb begin
    // x^8 + x^6 + x^5 + x^4 + 1
    feedback  = lfsrQ[7] ^ lfsrQ[5] ^ lfsrQ[4] ^ lfsrQ[3];
    lfsrD     = {lfsrQ[LFSR_W-2:0], feedback};
    stall     = lfsrQ[0] && (stallCntQ < STALL_CNT_W'(MAX_STALL));
    stallCntD = '0;
    if (idle && cmdValid && stall) begin
      stallCntD = stallCntQ + CntOne;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsrQ     <= LFSR_SEED;
      stallCntQ <= '0;
    end else begin
      lfsrQ     <= lfsrD;
      stallCntQ <= stallCntD;
    end
  end

endmodule

// File: rtl/mr1_dbus_responder.sv
// Memory-side responder for the MR1 dBus: word-addressed RAM with byte-lane stores and
// fixed-latency load responses, optionally throttled by pseudo-random back-pressure.
module mr1_dbus_responder
  import mr1_bus_pkg::*;
#(
  parameter int unsigned       MEM_WORDS  = 256,
  parameter int unsigned       RD_LATENCY = 2,
  parameter int unsigned       STALL_EN   = 1,
  parameter int unsigned       MAX_STALL  = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
  input logic                 clock,
  input logic                 reset,
  mr1_dbus_responder_if.slave dBus
);

  localparam int unsigned AW          = $clog2(MEM_WORDS);
  localparam int unsigned WAIT_CYCLES = RD_LATENCY - 1;
  localparam int unsigned LAT_W       = 8;

  state_e            stateQ, stateD;
  logic [LAT_W-1:0]  latCntQ, latCntD;
  logic [AW-1:0]     rdIdxQ, rdIdxD;
  logic              rdErrQ, rdErrD;
  logic [31:0]       rspDataQ, rspDataD;
  logic              rspErrQ, rspErrD;

  logic              inIdle, stall, cmdReady, accept;
  size_e             cmdSize;
  logic [1:0]        lane;
  logic              outOfRange, badAccess;
  logic [AW-1:0]     wordIdx;
  logic [3:0]        wrEn;
  logic [31:0]       wrData;
  logic [AW-1:0]     srcIdx;
  logic              srcErr;

  logic [3:0][7:0]   mem [MEM_WORDS];

  // Command decode
  assign cmdSize    = size_e'(dBus.cmd_payload_size);
  assign lane       = dBus.cmd_payload_address[1:0];
  assign wordIdx    = dBus.cmd_payload_address[AW+1:2];
  assign outOfRange = |dBus.cmd_payload_address[31:AW+2];
  assign badAccess  = outOfRange || misaligned(cmdSize, lane);

  assign inIdle   = (stateQ == StIdle);
  assign cmdReady = inIdle && !stall;
  // Commands are never taken during a reset cycle, so RAM stays untouched then.
  assign accept   = dBus.cmd_valid && cmdReady && reset;

  if (STALL_EN != 0) begin : gen_stall
    mr1_stall_gen #(
      .MAX_STALL (MAX_STALL),
      .LFSR_SEED (LFSR_SEED)
    ) u_stall_gen (
      .clock    (clock),
      .reset    (reset),
      .idle     (inIdle),
      .cmdValid (dBus.cmd_valid),
      .stall    (stall)
    );
  end else begin : gen_no_stall
    assign stall = 1'b0;
  end

  // Store path: lane-replicated data, byte enables select which lanes land.
  always_comb begin
    wrEn = 4'b0000;
    if (accept && dBus.cmd_payload_wr && !badAccess) begin
      wrEn = byte_en(cmdSize, lane);
    end
    unique case (cmdSize)
      SZ_BYTE: wrData = {4{dBus.cmd_payload_data[7:0]}};
      SZ_HALF: wrData = {2{dBus.cmd_payload_data[15:0]}};
      default: wrData = dBus.cmd_payload_data;
    endcase
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wrEn[b]) begin
        mem[wordIdx][b] <= wrData[8*b +: 8];
      end
    end
  end

  // Load sequencing
  always_comb begin
    stateD  = stateQ;
    latCntD = latCntQ;
    rdIdxD  = rdIdxQ;
    rdErrD  = rdErrQ;
    unique case (stateQ)
      StReset: stateD = StIdle;
      StIdle: begin
        if (accept && !dBus.cmd_payload_wr) begin
          rdIdxD  = wordIdx;
          rdErrD  = badAccess;
          latCntD = '0;
          stateD  = (WAIT_CYCLES == 0) ? StResp : StRdWait;
        end
      end
      StRdWait: begin
        latCntD = latCntQ + LAT_W'(1);
        if (latCntQ == LAT_W'(WAIT_CYCLES - 1)) begin
          stateD = StResp;
        end
      end
      StResp:  stateD = StIdle;
      default: stateD = StReset;
    endcase
  end

  // With a single-cycle latency the response is formed straight from the live command.
  always_comb begin
    srcIdx   = inIdle ? wordIdx : rdIdxQ;
    srcErr   = inIdle ? badAccess : rdErrQ;
    rspDataD = rspDataQ;
    rspErrD  = rspErrQ;
    if (stateD == StResp) begin
      rspDataD = srcErr ? 32'h0 : mem[srcIdx];
      rspErrD  = srcErr;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stateQ   <= StReset;
      latCntQ  <= '0;
      rdIdxQ   <= '0;
      rdErrQ   <= 1'b0;
      rspDataQ <= 32'h0;
      rspErrQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      latCntQ  <= latCntD;
      rdIdxQ   <= rdIdxD;
      rdErrQ   <= rdErrD;
      rspDataQ <= rspDataD;
      rspErrQ  <= rspErrD;
    end
  end

  assign dBus.cmd_ready = cmdReady;
  assign dBus.rsp_ready = (stateQ == StResp);
  assign dBus.rsp_data  = rspDataQ;
  assign dBus.rsp_error = rspErrQ;

endmodule

// File: tb/tb_mr1_dbus_responder.sv
// Directed bench for mr1_dbus_responder with a behavioural memory/latency model checked every cycle.
module tb_mr1_dbus_responder;
  import mr1_bus_pkg::*;

  localparam int unsigned MEM_WORDS  = 256;
  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned MAX_STALL  = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mr1_dbus_responder_if dBus ();
  mr1_dbus_responder_if dBusNs ();

  mr1_dbus_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .RD_LATENCY (RD_LATENCY),
    .STALL_EN   (1),
    .MAX_STALL  (MAX_STALL),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .dBus  (dBus)
  );

  mr1_dbus_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .RD_LATENCY (RD_LATENCY),
    .STALL_EN   (0),
    .MAX_STALL  (MAX_STALL),
    .LFSR_SEED  (8'hA5)
  ) dutNoStall (
    .clock (clock),
    .reset (reset),
    .dBus  (dBusNs)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] modelMem [MEM_WORDS];
  logic        pendValid = 1'b0;
  int          pendDue   = 0;
  logic [31:0] pendData  = 32'h0;
  logic        pendErr   = 1'b0;
  logic [31:0] lastData  = 32'h0;
  logic        lastErr   = 1'b0;
  logic        prevReset = 1'b0;
  logic        armed     = 1'b0;
  int          cyc = 0, run = 0, maxRun = 0, stallSeen = 0;

  function automatic logic illegal(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr >= 4 * MEM_WORDS);
  endfunction

  task automatic modelStore(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data);
    int idx;
    int off;
    logic [31:0] w;
    if (illegal(size, addr)) return;
    idx = int'(addr / 4);
    off = int'(addr % 4);
    w   = modelMem[idx];
    if (size == 2'd0)      w[8*off +: 8]  = data[7:0];
    else if (size == 2'd1) w[8*off +: 16] = data[15:0];
    else                   w = data;
    modelMem[idx] = w;
  endtask

  // Samples are taken on the falling edge; sample k precedes rising edge k.
  always @(negedge clock) begin : mon
    logic expRsp;
    logic busy;
    cyc++;
    if (armed) begin
      check("nostall_ready", dBusNs.cmd_ready, prevReset);
      if (!prevReset) begin
        check("reset_cmd_ready", dBus.cmd_ready, 0);
        check("reset_rsp_ready", dBus.rsp_ready, 0);
        check("reset_rsp_data", dBus.rsp_data, 0);
        check("reset_rsp_error", dBus.rsp_error, 0);
      end else begin
        busy   = pendValid;
        expRsp = pendValid && (cyc == pendDue);
        check("rsp_ready", dBus.rsp_ready, expRsp);
        if (expRsp) begin
          check("rsp_data", dBus.rsp_data, pendData);
          check("rsp_error", dBus.rsp_error, pendErr);
          lastData  = pendData;
          lastErr   = pendErr;
          pendValid = 1'b0;
        end else begin
          check("rsp_data_hold", dBus.rsp_data, lastData);
          check("rsp_error_hold", dBus.rsp_error, lastErr);
        end
        if (busy) check("cmd_ready_busy", dBus.cmd_ready, 0);
        if (!busy && dBus.cmd_valid && !dBus.cmd_ready) begin
          run++;
          stallSeen++;
        end else begin
          run = 0;
        end
        if (run > maxRun) maxRun = run;
        if (reset && dBus.cmd_valid && dBus.cmd_ready) begin
          if (dBus.cmd_payload_wr) begin
            modelStore(dBus.cmd_payload_size, dBus.cmd_payload_address, dBus.cmd_payload_data);
          end else begin
            pendValid = 1'b1;
            pendDue   = cyc + int'(RD_LATENCY);
            pendErr   = illegal(dBus.cmd_payload_size, dBus.cmd_payload_address);
            pendData  = pendErr ? 32'h0 : modelMem[int'(dBus.cmd_payload_address / 4)];
          end
        end
      end
    end
    if (!reset) begin
      armed     = 1'b1;
      pendValid = 1'b0;
      lastData  = 32'h0;
      lastErr   = 1'b0;
      run       = 0;
    end
    prevReset = reset;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data);
    bit done = 1'b0;
    @(posedge clock);
    #1;
    dBus.cmd_valid           = 1'b1;
    dBus.cmd_payload_wr      = wr;
    dBus.cmd_payload_size    = size;
    dBus.cmd_payload_address = addr;
    dBus.cmd_payload_data    = data;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (dBus.cmd_ready === 1'b1) done = 1'b1;
    end
    if (!done) check("accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    dBus.cmd_valid = 1'b0;
  endtask

  task automatic doLoad(input logic [1:0] size, input logic [31:0] addr,
                        output logic [31:0] data, output logic err, output int lat);
    bit done = 1'b0;
    issue(1'b0, size, addr, 32'h0);
    lat  = 0;
    data = 32'hFFFF_FFFF;
    err  = 1'bx;
    for (int i = 1; i <= 10 && !done; i++) begin
      @(negedge clock);
      if (dBus.rsp_ready === 1'b1) begin
        lat  = i;
        data = dBus.rsp_data;
        err  = dBus.rsp_error;
        done = 1'b1;
      end
    end
    if (!done) check("rsp_timeout", 0, 1);
  endtask

  initial begin
    dBusNs.cmd_valid           = 1'b1;
    dBusNs.cmd_payload_wr      = 1'b1;
    dBusNs.cmd_payload_size    = 2'd2;
    dBusNs.cmd_payload_address = 32'h20;
    dBusNs.cmd_payload_data    = 32'h0BAD_F00D;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          pulses;
    dBus.cmd_valid           = 1'b0;
    dBus.cmd_payload_wr      = 1'b0;
    dBus.cmd_payload_size    = 2'd0;
    dBus.cmd_payload_address = 32'h0;
    dBus.cmd_payload_data    = 32'h0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("init_cmd_ready", dBus.cmd_ready, 0);
    check("init_rsp_ready", dBus.rsp_ready, 0);
    check("init_rsp_data", dBus.rsp_data, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Load accepted, then reset on the very next edge: the response must never appear.
    issue(1'b0, 2'd2, 32'h0, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clock);
      if (dBus.rsp_ready === 1'b1) pulses++;
    end
    check("midload_no_rsp", pulses, 0);

    issue(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF);
    doLoad(2'd2, 32'h10, d, e, lat);
    check("word_data", d, 32'hDEAD_BEEF);
    check("word_err", e, 0);
    check("word_latency", lat, 2);

    issue(1'b1, 2'd2, 32'h10, 32'h1122_3344);
    issue(1'b1, 2'd0, 32'h13, 32'h0000_0055);
    doLoad(2'd2, 32'h10, d, e, lat);
    check("byte_lane_data", d, 32'h5522_3344);
    issue(1'b1, 2'd1, 32'h12, 32'h0000_ABCD);
    doLoad(2'd2, 32'h10, d, e, lat);
    check("half_lane_data", d, 32'hABCD_3344);

    doLoad(2'd1, 32'h11, d, e, lat);
    check("misalign_load_err", e, 1);
    check("misalign_load_data", d, 0);
    issue(1'b1, 2'd2, 32'h14, 32'h0102_0304);
    issue(1'b1, 2'd2, 32'h16, 32'hFFFF_FFFF);
    doLoad(2'd2, 32'h14, d, e, lat);
    check("misalign_store_dropped", d, 32'h0102_0304);
    doLoad(2'd3, 32'h10, d, e, lat);
    check("size3_load_err", e, 1);

    issue(1'b1, 2'd2, 32'h0, 32'hCAFE_F00D);
    issue(1'b1, 2'd2, 32'h400, 32'h0);
    doLoad(2'd2, 32'h0, d, e, lat);
    check("oor_store_dropped", d, 32'hCAFE_F00D);
    doLoad(2'd2, 32'h400, d, e, lat);
    check("oor_load_err", e, 1);
    check("oor_load_data", d, 0);
    issue(1'b1, 2'd2, 32'h3FC, 32'h7777_8888);
    doLoad(2'd2, 32'h3FC, d, e, lat);
    check("last_word_data", d, 32'h7777_8888);
    check("last_word_err", e, 0);

    // Held valid with a payload that changes every cycle until each accept.
    @(posedge clock);
    #1;
    dBus.cmd_valid           = 1'b1;
    dBus.cmd_payload_wr      = 1'b1;
    dBus.cmd_payload_size    = 2'd2;
    dBus.cmd_payload_address = 32'h40;
    for (int i = 0; i < 1000; i++) begin
      dBus.cmd_payload_data = 32'h1000_0000 + i;
      @(posedge clock);
      #1;
    end
    dBus.cmd_valid = 1'b0;
    doLoad(2'd2, 32'h40, d, e, lat);
    check("stall_bound", (maxRun <= int'(MAX_STALL)), 1);
    check("stall_max_reached", maxRun, MAX_STALL);
    check("stall_seen", (stallSeen > 0), 1);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
